// File: rtl/loader_pkg.sv
// Shared FSM encoding and constants for the program loader.
package loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone
    } state_e;

    localparam logic [31:0] BaseAddressDefault = 32'h0040_0000;
    localparam int unsigned CountWidth = 11;
    localparam int unsigned IndexWidth = 10;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
interface program_loader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    import loader_pkg::*;

    logic                  Start;
    logic [CountWidth-1:0] WordCount;
    logic [7:0]            ByteIn;
    logic                  ByteValid;
    logic                  ByteReady;
    logic                  MemWrite;
    logic [DATA_WIDTH-1:0] WriteAddress;
    logic [IndexWidth-1:0] WriteIndex;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  Busy;
    logic                  Done;
    logic                  Error;
    logic [DATA_WIDTH-1:0] Checksum;

    modport master (
        output Start, WordCount, ByteIn, ByteValid,
        input  ByteReady, MemWrite, WriteAddress, WriteIndex, WriteData,
        input  Busy, Done, Error, Checksum
    );

    modport slave (
        input  Start, WordCount, ByteIn, ByteValid,
        output ByteReady, MemWrite, WriteAddress, WriteIndex, WriteData,
        output Busy, Done, Error, Checksum
    );

endinterface

// File: rtl/word_assembler.sv
// Big-endian byte-to-word shift register with a modulo-4 byte counter.
module word_assembler #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  last_o
);

    logic [1:0]            cnt_q;
    logic [DATA_WIDTH-1:0] word_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else if (clear_i) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else if (push_i) begin
            // Earlier bytes move toward the MSBs, so the first byte ends up on top.
            cnt_q  <= cnt_q + 2'd1;
            word_q <= {word_q[DATA_WIDTH-9:0], byte_i};
        end
    end

    assign word_o = word_q;
    assign last_o = push_i && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a byte stream and writes big-endian words to program memory.
// Define LOADER_CHECKSUM_EN to build the running word-sum Checksum output.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEMORY_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDRESS = BaseAddressDefault
) (
    input logic             clk,
    input logic             reset,
    program_loader_if.slave bus_io
);

    state_e                state_q;
    logic [CountWidth-1:0] count_q;
    logic [IndexWidth-1:0] index_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic                  ready_q;
    logic                  write_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic                  start_ok;
    logic                  accept;
    logic                  push;
    logic                  last;
    logic [DATA_WIDTH-1:0] word;

    assign start_ok = (bus_io.WordCount != '0) && (32'(bus_io.WordCount) <= MEMORY_DEPTH);
    assign accept   = (state_q == StIdle) && bus_io.Start && start_ok;
    assign push     = ready_q && bus_io.ByteValid;

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_assembler (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (accept),
        .push_i  (push),
        .byte_i  (bus_io.ByteIn),
        .word_o  (word),
        .last_o  (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            index_q <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            write_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.Start) begin
                        if (start_ok) begin
                            count_q <= bus_io.WordCount;
                            index_q <= '0;
                            addr_q  <= DATA_WIDTH'(BASE_ADDRESS);
                            error_q <= 1'b0;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= StRecv;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                StRecv: begin
                    if (last) begin
                        ready_q <= 1'b0;
                        write_q <= 1'b1;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if ({1'b0, index_q} == count_q - CountWidth'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        index_q <= index_q + IndexWidth'(1);
                        addr_q  <= addr_q + DATA_WIDTH'(4);
                        ready_q <= 1'b1;
                        state_q <= StRecv;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (state_q == StWrite) begin
            sum_q <= sum_q + word;
        end
    end

    assign bus_io.Checksum = sum_q;
`else
    assign bus_io.Checksum = '0;
`endif

    assign bus_io.ByteReady    = ready_q;
    assign bus_io.MemWrite     = write_q;
    assign bus_io.WriteAddress = addr_q;
    assign bus_io.WriteIndex   = index_q;
    assign bus_io.WriteData    = word;
    assign bus_io.Busy         = busy_q;
    assign bus_io.Done         = done_q;
    assign bus_io.Error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: request table, directed loads and random byte streams.
module tb_program_loader;

    localparam logic [31:0] Base = 32'h0040_0000;

    logic clk;
    logic reset;

    program_loader_if #(.DATA_WIDTH(32)) bus ();

    program_loader #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (1024),
        .BASE_ADDRESS (Base)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt;
    logic [31:0] wr_idx_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] words_q[$];

    typedef struct {
        logic [10:0] wc;
        bit          exp_err;
        bit          exp_busy;
    } req_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance one cycle and log any write or done pulse seen after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.MemWrite === 1'b1) begin
            wr_idx_q.push_back(32'(bus.WriteIndex));
            wr_addr_q.push_back(bus.WriteAddress);
            wr_data_q.push_back(bus.WriteData);
            chk("ready_in_write", 32'(bus.ByteReady), 0);
        end
        if (bus.Done === 1'b1) begin
            done_cnt++;
            chk("ready_in_done", 32'(bus.ByteReady), 0);
            chk("busy_in_done", 32'(bus.Busy), 1);
        end
    endtask

    task automatic check_zero();
        chk("zero_ready", 32'(bus.ByteReady), 0);
        chk("zero_memwrite", 32'(bus.MemWrite), 0);
        chk("zero_addr", bus.WriteAddress, 0);
        chk("zero_index", 32'(bus.WriteIndex), 0);
        chk("zero_data", bus.WriteData, 0);
        chk("zero_busy", 32'(bus.Busy), 0);
        chk("zero_done", 32'(bus.Done), 0);
        chk("zero_error", 32'(bus.Error), 0);
        chk("zero_checksum", bus.Checksum, 0);
    endtask

    // Reset is raised and checked between clock edges to exercise the asynchronous path.
    task automatic do_reset();
        #2 reset = 1'b1;
        #2 check_zero();
        bus.Start     = 1'b0;
        bus.ByteValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();
        check_zero();
    endtask

    // Load words_q; abort_at >= 0 resets the DUT before that byte number is offered.
    task automatic run_load(input int gap_max, input bit poke_start, input int abort_at);
        int n = words_q.size();
        int nb = 0;
        int exp_n;
        bit aborted = 1'b0;
        logic [31:0] exp_sum = '0;
        wr_idx_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;

        bus.Start     = 1'b1;
        bus.WordCount = 11'(n);
        step();
        bus.Start = 1'b0;
        chk("busy_after_start", 32'(bus.Busy), 1);
        chk("error_cleared", 32'(bus.Error), 0);
        chk("ready_after_start", 32'(bus.ByteReady), 1);

        for (int k = 0; k < 4 * n && !aborted; k++) begin
            int w = k / 4;
            int b = k % 4;
            bit got = 1'b0;
            if (abort_at == nb) begin
                do_reset();
                aborted = 1'b1;
            end else begin
                repeat ($urandom_range(gap_max, 0)) step();
                bus.ByteIn    = words_q[w][31-8*b -: 8];
                bus.ByteValid = 1'b1;
                if (poke_start && nb == 5) begin
                    bus.Start     = 1'b1;
                    bus.WordCount = 11'(n + 3);
                end
                for (int t = 0; t < 20 && !got; t++) begin
                    got = bus.ByteReady;
                    step();
                    bus.Start = 1'b0;
                end
                if (!got) chk("byte_accept_timeout", 0, 1);
                if (got && b == 3) chk("write_latency", 32'(bus.MemWrite), 1);
                bus.ByteValid = 1'b0;
                nb++;
            end
        end

        if (!aborted) begin
            for (int t = 0; t < 10 && done_cnt == 0; t++) step();
            step();
            chk("busy_after_done", 32'(bus.Busy), 0);
            chk("ready_in_idle", 32'(bus.ByteReady), 0);
            foreach (words_q[i]) exp_sum += words_q[i];
`ifdef LOADER_CHECKSUM_EN
            chk("checksum", bus.Checksum, exp_sum);
`else
            chk("checksum", bus.Checksum, 0);
`endif
        end

        exp_n = aborted ? abort_at / 4 : n;
        chk("write_count", 32'(wr_idx_q.size()), 32'(exp_n));
        chk("done_count", 32'(done_cnt), aborted ? 0 : 1);
        for (int i = 0; i < exp_n && i < wr_idx_q.size(); i++) begin
            chk("write_index", wr_idx_q[i], 32'(i));
            chk("write_addr", wr_addr_q[i], Base + 32'(4 * i));
            chk("write_data", wr_data_q[i], words_q[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_t reqs[6];
        reqs[0] = '{wc: 11'd0,    exp_err: 1'b1, exp_busy: 1'b0};
        reqs[1] = '{wc: 11'd1025, exp_err: 1'b1, exp_busy: 1'b0};
        reqs[2] = '{wc: 11'd1,    exp_err: 1'b0, exp_busy: 1'b1};
        reqs[3] = '{wc: 11'd2047, exp_err: 1'b1, exp_busy: 1'b0};
        reqs[4] = '{wc: 11'd1024, exp_err: 1'b0, exp_busy: 1'b1};
        reqs[5] = '{wc: 11'd0,    exp_err: 1'b1, exp_busy: 1'b0};

        reset         = 1'b1;
        bus.Start     = 1'b0;
        bus.WordCount = '0;
        bus.ByteIn    = '0;
        bus.ByteValid = 1'b0;
        done_cnt      = 0;
        #7 check_zero();
        @(negedge clk);
        reset = 1'b0;
        step();

        foreach (reqs[i]) begin
            wr_idx_q.delete();
            bus.WordCount = reqs[i].wc;
            bus.Start     = 1'b1;
            step();
            bus.Start = 1'b0;
            chk("req_error", 32'(bus.Error), 32'(reqs[i].exp_err));
            chk("req_busy", 32'(bus.Busy), 32'(reqs[i].exp_busy));
            chk("req_ready", 32'(bus.ByteReady), 32'(reqs[i].exp_busy));
            step();
            chk("req_busy_held", 32'(bus.Busy), 32'(reqs[i].exp_busy));
            chk("req_no_write", 32'(wr_idx_q.size()), 0);
            if (reqs[i].exp_busy) do_reset();
        end

        // Fixed two-word stream, back-to-back bytes.
        words_q = '{32'h2008_0005, 32'h2409_000A};
        run_load(0, 1'b0, -1);

        // Checksum wraps modulo 2^32.
        words_q = '{32'hFFFF_FFFF, 32'h0000_0002};
        run_load(2, 1'b0, -1);

        for (int k = 0; k < 8; k++) begin
            int n = $urandom_range(6, 2);
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            run_load(3, k[0], -1);
        end

        // Reset after two bytes of word 3, then reload from index 0.
        words_q.delete();
        for (int i = 0; i < 5; i++) words_q.push_back($urandom);
        run_load(1, 1'b0, 14);
        words_q = '{32'hCAFE_F00D};
        run_load(1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 1024, words of program memory.
REQ-003 SHALL have parameter BASE_ADDRESS, default 32'h0040_0000, byte address of word 0.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port Start, input, 1, one-cycle load request.
REQ-007 SHALL have port WordCount, input, 11, number of words to load; sampled on the Start cycle.
REQ-008 SHALL have port ByteIn, input, 8, incoming program byte.
REQ-009 SHALL have port ByteValid, input, 1, ByteIn is valid this cycle.
REQ-010 SHALL have port ByteReady, output, 1, loader accepts a byte this cycle.
REQ-011 SHALL have port MemWrite, output, 1, program-memory write strobe.
REQ-012 SHALL have port WriteAddress, output, DATA_WIDTH, byte address of the word being written.
REQ-013 SHALL have port WriteIndex, output, 10, word index of the word being written, equal to (WriteAddress-BASE_ADDRESS)/4.
REQ-014 SHALL have port WriteData, output, DATA_WIDTH, assembled instruction word.
REQ-015 SHALL have ports Busy, Done and Error, each output, 1: load in progress, load-complete pulse, and rejected request.
REQ-016 SHALL have port Checksum, output, DATA_WIDTH, running word sum (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, RECV, WRITE and DONE.
REQ-018 IDLE: on Start with 1<=WordCount<=MEMORY_DEPTH, SHALL latch WordCount, clear the word index, byte counter and Checksum, and go to RECV the next cycle.
REQ-019 IDLE: on Start with WordCount=0 or WordCount>MEMORY_DEPTH, SHALL set Error, which holds until the next accepted Start, and SHALL stay in IDLE.
REQ-020 RECV: ByteReady=1; a byte transfers only when ByteValid&&ByteReady; the byte counter increments modulo 4.
REQ-021 Byte order SHALL be big-endian: the first byte goes to WriteData[31:24] and the fourth to [7:0].
REQ-022 On the transfer of the fourth byte, SHALL go to WRITE; ByteReady=0 in every state other than RECV.
REQ-023 WRITE: SHALL assert MemWrite for exactly one cycle with WriteData stable, WriteIndex=index and WriteAddress=BASE_ADDRESS+4*index.
REQ-024 After WRITE: if index==count-1, SHALL go to DONE; otherwise SHALL increment index and return to RECV.
REQ-025 DONE: SHALL assert Done for one cycle, then go to IDLE.
REQ-026 Busy SHALL be 1 in RECV, WRITE and DONE.
REQ-027 Start SHALL be ignored while Busy.
REQ-028 ByteValid outside RECV SHALL be ignored and no byte consumed.
REQ-029 Throughput: at most one word per 5 cycles; latency from fourth-byte transfer to MemWrite is exactly 1 cycle.
REQ-030 Address arithmetic SHALL be DATA_WIDTH-bit unsigned with no wrap check beyond REQ-019.

Reset
REQ-031 reset SHALL force IDLE immediately and asynchronously, even mid-load.
REQ-032 reset SHALL clear all outputs, counters and the WriteData register to 0.
REQ-033 After reset, a partially loaded word SHALL be discarded and not written.

Configuration
REQ-034 With LOADER_CHECKSUM_EN defined, Checksum SHALL be the modulo-2^DATA_WIDTH sum of all words written since the last accepted Start, updated in the WRITE cycle and held after DONE.
REQ-035 Without LOADER_CHECKSUM_EN, Checksum SHALL be tied to 0 and no adder SHALL be synthesized.

Structure
REQ-036 FSM state encodings and the BASE_ADDRESS default SHALL live in shared package loader_pkg.
REQ-037 Byte-to-word assembly (shift register plus byte counter) SHALL be sub-module word_assembler; the FSM and address generation SHALL stay in program_loader.

Verification
REQ-038 Start, WordCount=2, bytes 20 08 00 05 24 09 00 0A -> MemWrite at index 0/addr 0x00400000 data 0x20080005, then index 1/addr 0x00400004 data 0x2409000A; Done pulses once.
REQ-039 Start, WordCount=0 and again with WordCount=1025 -> Error=1, Busy=0, no MemWrite; a following valid Start clears Error.
REQ-040 Insert ByteValid gaps of 0-3 cycles between bytes -> identical writes; ByteReady=0 during WRITE and DONE.
REQ-041 Assert reset after 2 bytes of word 3 -> IDLE, all outputs 0, no write of word 3; a new Start reloads from index 0.
REQ-042 Start pulsed while Busy -> ignored, WordCount unchanged.
REQ-043 With LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 -> Checksum=0x00000001; without the macro -> Checksum=0.
